// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle controller: FSM state encodings,
// instruction opcodes, ALU class codes, memory access sizes and the decoded
// instruction record passed from mc_decode to mc_controller.
// ----------------------------------------------------------------------------
package mc_pkg;

  // FSM state encodings. These values are visible on the controller's state port.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  // Opcode field values, taken from instruction bits [31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALU class codes. ALU_FUNCT tells the ALU to decode funct on its own.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  // Memory access sizes.
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Instruction classes. These are the only classes the FSM distinguishes.
  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_ORI,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_JUMP,
    CLS_ILLEGAL
  } inst_class_e;

  typedef struct packed {
    inst_class_e cls;
    logic        alu_src;   // immediate operand instead of the second register
    logic [3:0]  alu_op;
    logic [1:0]  mem_size;
  } decode_t;

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode
// Purely combinational opcode decoder. It maps the opcode to an instruction
// class plus the static datapath selections for that class. The FSM decides
// when those selections are actually driven onto the outputs.
// Ports:
//   opcode (in, 6) : instruction [31:26]
//   funct  (in, 6) : instruction [5:0]. Only the ALU interprets this field.
//   dec    (out)   : decoded record (class, alu_src, alu_op, mem_size)
// ----------------------------------------------------------------------------
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // The ALU decodes R-type operations from funct directly, so the controller
  // does not need it. The signal is kept so the decoder has the complete
  // instruction fields at its interface.
  logic unused_funct;
  assign unused_funct = ^funct;

  // NOTE: every field gets a default before the case statement. A path that
  // leaves a field unassigned would infer a latch.
  always_comb begin
    dec          = '0;
    dec.cls      = CLS_ILLEGAL;
    dec.alu_op   = ALU_ADD;
    dec.mem_size = MEM_BYTE;
    case (opcode)
      OP_RTYPE: begin dec.cls = CLS_RTYPE;                    dec.alu_op = ALU_FUNCT; end
      OP_ADDI:  begin dec.cls = CLS_ADDI;  dec.alu_src = 1'b1;                         end
      OP_ORI:   begin dec.cls = CLS_ORI;   dec.alu_src = 1'b1; dec.alu_op = ALU_OR;   end
      OP_LW:    begin dec.cls = CLS_LOAD;  dec.alu_src = 1'b1; dec.mem_size = MEM_WORD; end
      OP_LB:    begin dec.cls = CLS_LOAD;  dec.alu_src = 1'b1;                         end
      OP_SW:    begin dec.cls = CLS_STORE; dec.alu_src = 1'b1; dec.mem_size = MEM_WORD; end
      OP_SB:    begin dec.cls = CLS_STORE; dec.alu_src = 1'b1;                         end
      OP_BEQ:   begin dec.cls = CLS_BEQ;                      dec.alu_op = ALU_SUB;   end
      OP_BNE:   begin dec.cls = CLS_BNE;                      dec.alu_op = ALU_SUB;   end
      OP_J:     begin dec.cls = CLS_JUMP;                                              end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
// Multi-cycle processor control FSM with PC register.
// Sequence: FETCH -> DECODE -> EXECUTE -> {MEM} -> {WB} -> FETCH. Control
// branches return to FETCH directly from EXECUTE.
// Configuration macro: MC_CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// illegal opcode enters TRAP for one cycle and then retires to TRAP_PC.
// When it is not defined, an illegal opcode retires in EXECUTE as a NOP.
// Ports:
//   clock, reset               : rising-edge clock, async active-high reset
//   opcode, funct              : instruction fields
//   alu_zero                   : ALU equality flag, used by beq and bne
//   branch_target, jump_target : precomputed next-PC candidates
//   inst_ready, mem_ready      : memory handshakes
//   pc                         : current PC
//   ir_load ... mem_we         : single-bit datapath controls
//   alu_op, mem_size           : ALU class and memory access size
//   state                      : current FSM state
//   retire                     : high in the cycle in which pc updates
// ----------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000,
  parameter logic [XLEN-1:0] TRAP_PC  = 32'h8000_0180
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic            inst_ready,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            ir_load,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            mem_re,
  output logic            mem_we,
  output logic [3:0]      alu_op,
  output logic [1:0]      mem_size,
  output logic [2:0]      state,
  output logic            retire
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  decode_t         dec;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples values from before the clock edge, whatever order the processes
  // are evaluated in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are decoded from state_q. The async reset forces state_q to FETCH
  // at once, so all outputs except ir_load go to 0 without waiting for a clock
  // edge. ir_load is gated by reset explicitly.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_load    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_op     = ALU_ADD;
    mem_size   = MEM_BYTE;
    retire     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (inst_ready) begin
          ir_load = ~reset;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = ST_EXECUTE;

      ST_EXECUTE: begin
        alu_src = dec.alu_src;
        alu_op  = dec.alu_op;
        case (dec.cls)
          CLS_RTYPE, CLS_ADDI, CLS_ORI: state_d = ST_WB;
          CLS_LOAD, CLS_STORE:          state_d = ST_MEM;
          CLS_BEQ, CLS_BNE, CLS_JUMP: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            retire  = 1'b1;
            state_d = ST_FETCH;
`endif
          end
        endcase
      end

      ST_MEM: begin
        mem_size = dec.mem_size;
        mem_re   = (dec.cls == CLS_LOAD);
        mem_we   = (dec.cls == CLS_STORE);
        if (mem_ready) begin
          if (dec.cls == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (dec.cls == CLS_RTYPE);
        mem_to_reg = (dec.cls == CLS_LOAD);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_TRAP: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // The PC moves only when an instruction retires. A taken control transfer
    // overrides the sequential pc+4, which wraps modulo 2^XLEN.
    if (retire) begin
      if (state_q == ST_TRAP) begin
        pc_d = TRAP_PC;
      end else if (dec.cls == CLS_JUMP) begin
        pc_d = jump_target;
      end else if ((dec.cls == CLS_BEQ && alu_zero) || (dec.cls == CLS_BNE && !alu_zero)) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
      end
    end
  end

  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_mc_controller
// Directed testbench for mc_controller. It uses hand-computed expected values
// for PC, state and control outputs across add, lw, branches, jump, PC wrap,
// illegal opcode, sb and reset during a store.
// Build with or without MC_CTRL_ILLEGAL_TRAP_EN. The expected values for the
// illegal opcode follow the macro.
// ----------------------------------------------------------------------------
module tb_mc_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        alu_zero;
  logic [31:0] branch_target, jump_target;
  logic        inst_ready, mem_ready;
  logic [31:0] pc;
  logic        ir_load, reg_write, reg_dst, alu_src, mem_to_reg, mem_re, mem_we;
  logic [3:0]  alu_op;
  logic [1:0]  mem_size;
  logic [2:0]  state;
  logic        retire;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_pc;

  mc_controller dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .inst_ready    (inst_ready),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .ir_load       (ir_load),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src       (alu_src),
    .mem_to_reg    (mem_to_reg),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .alu_op        (alu_op),
    .mem_size      (mem_size),
    .state         (state),
    .retire        (retire)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Fetch and decode one instruction. On return the FSM is in EXECUTE.
  task automatic fetch_decode(input logic [5:0] op);
    opcode     = op;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0;
    branch_target = '0; jump_target = '0; inst_ready = 1'b1; mem_ready = 1'b0;

    // Reset state, with inst_ready high during reset.
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    #5;
    reset = 1'b0; inst_ready = 1'b0;

    // FETCH holds without inst_ready. A mem_ready pulse here is ignored.
    mem_ready = 1'b1;
    tick();
    check("hold_state", 32'(state), 32'd0);
    check("hold_mem_re", 32'(mem_re), 32'd0);
    check("hold_pc", pc, 32'h0040_0000);
    mem_ready = 1'b0;

    // add: states 0,1,2,4, then retire to pc+4.
    opcode = 6'h00; funct = 6'h20; inst_ready = 1'b1; #1;
    check("add_ir_load", 32'(ir_load), 32'd1);
    tick();
    inst_ready = 1'b0;
    check("add_decode", 32'(state), 32'd1);
    check("add_ir_load_off", 32'(ir_load), 32'd0);
    tick();
    check("add_exec", 32'(state), 32'd2);
    check("add_alu_op", 32'(alu_op), 32'd15);
    check("add_alu_src", 32'(alu_src), 32'd0);
    tick();
    check("add_wb", 32'(state), 32'd4);
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_reg_dst", 32'(reg_dst), 32'd1);
    check("add_retire", 32'(retire), 32'd1);
    check("add_pc_wb", pc, 32'h0040_0000);
    tick();
    check("add_pc", pc, 32'h0040_0004);
    check("add_state_end", 32'(state), 32'd0);
    check("add_retire_off", 32'(retire), 32'd0);
    check("add_reg_write_off", 32'(reg_write), 32'd0);

    // lw: mem_ready low for 3 MEM cycles, high on the 4th.
    fetch_decode(6'h23);
    check("lw_alu_src", 32'(alu_src), 32'd1);
    check("lw_alu_op", 32'(alu_op), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw_mem_state%0d", i), 32'(state), 32'd3);
      check($sformatf("lw_mem_re%0d", i), 32'(mem_re), 32'd1);
      check($sformatf("lw_retire%0d", i), 32'(retire), 32'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check("lw_wb", 32'(state), 32'd4);
    check("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lw_reg_write", 32'(reg_write), 32'd1);
    check("lw_mem_re_off", 32'(mem_re), 32'd0);
    tick();
    check("lw_pc", pc, 32'h0040_0008);
    check("lw_retire_off", 32'(retire), 32'd0);

    // mem_size is observed inside MEM for lw. Run a second lw to check it.
    fetch_decode(6'h23);
    tick();
    check("lw_mem_size", 32'(mem_size), 32'd2);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    tick();
    check("lw2_pc", pc, 32'h0040_000C);

    // beq taken.
    alu_zero = 1'b1; branch_target = 32'h0040_0100;
    fetch_decode(6'h04);
    check("beq_alu_op", 32'(alu_op), 32'd1);
    check("beq_retire", 32'(retire), 32'd1);
    tick();
    check("beq_pc", pc, 32'h0040_0100);
    check("beq_state", 32'(state), 32'd0);

    // bne not taken (alu_zero=1).
    fetch_decode(6'h05);
    tick();
    check("bne_pc", pc, 32'h0040_0104);

    // j.
    jump_target = 32'h0040_0200;
    fetch_decode(6'h02);
    tick();
    check("j_pc", pc, 32'h0040_0200);

    // PC wrap: jump to 0xFFFF_FFFC, then ori retires to 0.
    jump_target = 32'hFFFF_FFFC;
    fetch_decode(6'h02);
    tick();
    check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    fetch_decode(6'h0D);
    check("ori_alu_op", 32'(alu_op), 32'd2);
    check("ori_alu_src", 32'(alu_src), 32'd1);
    tick();
    check("ori_reg_write", 32'(reg_write), 32'd1);
    check("ori_reg_dst", 32'(reg_dst), 32'd0);
    tick();
    check("wrap_pc", pc, 32'h0000_0000);

    // Illegal opcode 0x3F.
    fetch_decode(6'h3F);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    check("ill_exec_retire", 32'(retire), 32'd0);
    tick();
    check("ill_trap_state", 32'(state), 32'd5);
    check("ill_trap_retire", 32'(retire), 32'd1);
    check("ill_reg_write", 32'(reg_write), 32'd0);
    check("ill_mem_we", 32'(mem_we), 32'd0);
    tick();
    exp_pc = 32'h8000_0180;
`else
    check("ill_exec_retire", 32'(retire), 32'd1);
    check("ill_reg_write", 32'(reg_write), 32'd0);
    check("ill_mem_we", 32'(mem_we), 32'd0);
    tick();
    exp_pc = 32'h0000_0004;
`endif
    check("ill_pc", pc, exp_pc);
    check("ill_state", 32'(state), 32'd0);

    // sb: byte store, retires from MEM.
    fetch_decode(6'h28);
    tick();
    check("sb_mem_we", 32'(mem_we), 32'd1);
    check("sb_mem_re", 32'(mem_re), 32'd0);
    check("sb_mem_size", 32'(mem_size), 32'd0);
    mem_ready = 1'b1; #1;
    check("sb_retire", 32'(retire), 32'd1);
    tick();
    mem_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
    check("sb_pc", pc, exp_pc);

    // sw interrupted by reset while waiting in MEM.
    fetch_decode(6'h2B);
    tick();
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_mem_size", 32'(mem_size), 32'd2);
    tick();
    reset = 1'b1; #1;
    check("sw_rst_mem_we", 32'(mem_we), 32'd0);
    check("sw_rst_state", 32'(state), 32'd0);
    check("sw_rst_pc", pc, 32'h0040_0000);
    check("sw_rst_retire", 32'(retire), 32'd0);
    mem_ready = 1'b1; inst_ready = 1'b1;
    tick();
    check("sw_rst_hold_pc", pc, 32'h0040_0000);
    check("sw_rst_ir_load", 32'(ir_load), 32'd0);
    reset = 1'b0; mem_ready = 1'b0;

    // The first edge after reset is released evaluates FETCH.
    tick();
    inst_ready = 1'b0;
    check("post_rst_decode", 32'(state), 32'd1);
    check("post_rst_pc", pc, 32'h0040_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
